// File: rtl/csa_final_adder_seq.sv
// Sequential carry-propagate adder that resolves a carry-save pair CHUNK bits per cycle.
// Optional: define CSA_FINAL_OVF_EN to expose the final carry-out as ovf.
module csa_final_adder_seq #(
   parameter int W     = 19,
   parameter int CHUNK = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] cv_in,
   input  logic [W-1:0] sv_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] sum_out,
`ifdef CSA_FINAL_OVF_EN
   output logic         ovf,
`endif
   output logic         busy
);

   localparam int N     = (W + CHUNK - 1) / CHUNK;
   localparam int NW    = N * CHUNK;
   localparam int CW    = CHUNK + 1;
   localparam int LASTB = (W % CHUNK == 0) ? CHUNK : (W % CHUNK);
   localparam int IW    = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

   state_t          state;
   logic [W-1:0]    a_r, b_r;
   logic            carry;
   logic [IW-1:0]   idx;
   logic [NW-1:0]   a_pad, b_pad, res_pad;
   logic [CHUNK:0]  ssum;
   logic            last, cout;

   // Operands are zero-padded to N*CHUNK, so a short last slice adds zeros above
   // bit W-1 and the carry out of bit W-1 lands at ssum[LASTB].
   always_comb begin
      a_pad   = NW'(a_r);
      b_pad   = NW'(b_r);
      last    = (idx == IW'(N - 1));
      ssum    = {1'b0, a_pad[idx*CHUNK +: CHUNK]} + {1'b0, b_pad[idx*CHUNK +: CHUNK]} + CW'(carry);
      cout    = last ? ssum[LASTB] : ssum[CHUNK];
      res_pad = NW'(sum_out);
      res_pad[idx*CHUNK +: CHUNK] = ssum[CHUNK-1:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         sum_out   <= '0;
         carry     <= 1'b0;
         idx       <= '0;
         a_r       <= '0;
         b_r       <= '0;
`ifdef CSA_FINAL_OVF_EN
         ovf       <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  a_r      <= cv_in;
                  b_r      <= sv_in;
                  carry    <= 1'b0;
                  idx      <= '0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= ADD;
               end
            end
            ADD: begin
               sum_out <= res_pad[W-1:0];
               carry   <= cout;
               idx     <= last ? '0 : idx + 1'b1;
               if (last) begin
                  out_valid <= 1'b1;
                  state     <= DONE;
`ifdef CSA_FINAL_OVF_EN
                  ovf       <= cout;
`endif
               end
            end
            DONE: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_csa_final_adder_seq.sv
// Randomized bench for csa_final_adder_seq: three instances (CHUNK=4, 19, 5) against (cv+sv) mod 2^W.
module tb_csa_final_adder_seq;
   localparam int W = 19;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [2:0]        iv, ir, ov, ordy, bsy;
   logic [2:0][W-1:0] cv, sv, so;
`ifdef CSA_FINAL_OVF_EN
   logic [2:0]        ovf;
`endif
   int n_chk = 0;
   int n_pass = 0;

   csa_final_adder_seq #(.W(W), .CHUNK(4)) u_c4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .cv_in(cv[0]), .sv_in(sv[0]),
      .out_valid(ov[0]), .out_ready(ordy[0]), .sum_out(so[0]),
`ifdef CSA_FINAL_OVF_EN
      .ovf(ovf[0]),
`endif
      .busy(bsy[0]));

   csa_final_adder_seq #(.W(W), .CHUNK(19)) u_c19 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .cv_in(cv[1]), .sv_in(sv[1]),
      .out_valid(ov[1]), .out_ready(ordy[1]), .sum_out(so[1]),
`ifdef CSA_FINAL_OVF_EN
      .ovf(ovf[1]),
`endif
      .busy(bsy[1]));

   csa_final_adder_seq #(.W(W), .CHUNK(5)) u_c5 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .cv_in(cv[2]), .sv_in(sv[2]),
      .out_valid(ov[2]), .out_ready(ordy[2]), .sum_out(so[2]),
`ifdef CSA_FINAL_OVF_EN
      .ovf(ovf[2]),
`endif
      .busy(bsy[2]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full transaction on instance k; the reference is plain (a+b) split into sum and carry.
   task automatic run(input int k, input int n, input logic [W-1:0] a, input logic [W-1:0] b,
                      input string tag);
      int t;
      logic [W:0] full;
      full    = {1'b0, a} + {1'b0, b};
      ordy[k] = 1'b1;
      t = 0;
      while (!ir[k] && t < 100) begin tick(); t++; end
      check({tag, "_rdy"}, 32'(ir[k]), 32'd1);
      iv[k] = 1'b1; cv[k] = a; sv[k] = b;
      tick();
      iv[k] = 1'b0; cv[k] = W'($urandom); sv[k] = W'($urandom);
      t = 0;
      while (!ov[k] && t < 50) begin tick(); t++; end
      check({tag, "_lat"}, 32'(t), 32'(n));
      check({tag, "_sum"}, 32'(so[k]), 32'(full[W-1:0]));
`ifdef CSA_FINAL_OVF_EN
      check({tag, "_ovf"}, 32'(ovf[k]), 32'(full[W]));
`endif
      tick();
      check({tag, "_ovdrop"}, 32'(ov[k]), 32'd0);
      check({tag, "_irrise"}, 32'(ir[k]), 32'd1);
   endtask

   initial begin
      logic [W-1:0] held;
      iv = '0; ordy = '0; cv = '0; sv = '0;
      rst_n = 1'b0;
      repeat (3) tick();
      check("rst_in_ready", 32'(ir), 32'h7);
      check("rst_out_valid", 32'(ov), 32'h0);
      check("rst_busy", 32'(bsy), 32'h0);
      check("rst_sum", 32'(so[0]), 32'h0);
      rst_n = 1'b1;
      tick();

      run(0, 5, 19'h00002, 19'h00001, "basic");
      check("basic_const", 32'(so[0]), 32'h00003);
      run(0, 5, 19'h1FFFE, 19'h2FFFD, "max5x");
      check("max5x_const", 32'(so[0]), 32'h4FFFB);
      run(0, 5, 19'h7FFFF, 19'h00001, "ripple");
      check("ripple_const", 32'(so[0]), 32'h00000);

      // Stall in DONE: outputs hold and a new request is not taken.
      ordy[0] = 1'b0;
      iv[0] = 1'b1; cv[0] = 19'h00ABC; sv[0] = 19'h00111;
      tick();
      iv[0] = 1'b0;
      repeat (5) tick();
      held = 19'h00BCD;
      iv[0] = 1'b1; cv[0] = 19'h7FFFF; sv[0] = 19'h7FFFF;
      for (int i = 0; i < 10; i++) begin
         check("stall_ov", 32'(ov[0]), 32'd1);
         check("stall_sum", 32'(so[0]), 32'(held));
         check("stall_ir", 32'(ir[0]), 32'd0);
         tick();
      end
      iv[0] = 1'b0;
      ordy[0] = 1'b1;
      tick();
      check("stall_release_ov", 32'(ov[0]), 32'd0);
      check("stall_release_ir", 32'(ir[0]), 32'd1);
      repeat (6) tick();
      check("stall_once_ov", 32'(ov[0]), 32'd0);
      check("stall_once_busy", 32'(bsy[0]), 32'd0);
      check("stall_nolatch_sum", 32'(so[0]), 32'(held));

      // Reset during the third ADD cycle abandons the operation.
      iv[0] = 1'b1; cv[0] = 19'h55555; sv[0] = 19'h0AAAA;
      tick();
      iv[0] = 1'b0;
      tick(); tick();
      rst_n = 1'b0;
      tick();
      check("midrst_ir", 32'(ir[0]), 32'd1);
      check("midrst_ov", 32'(ov[0]), 32'd0);
      check("midrst_sum", 32'(so[0]), 32'd0);
      check("midrst_busy", 32'(bsy[0]), 32'd0);
      rst_n = 1'b1;
      repeat (7) tick();
      check("midrst_noout", 32'(ov[0]), 32'd0);
      run(0, 5, 19'h12345, 19'h01111, "postrst");
      check("postrst_const", 32'(so[0]), 32'h13456);

      for (int i = 0; i < 6; i++) run(0, 5, W'($urandom), W'($urandom), "rnd_c4");
      for (int i = 0; i < 8; i++) run(1, 1, W'($urandom), W'($urandom), "rnd_c19");
      run(1, 1, 19'h7FFFF, 19'h00001, "c19_ripple");
      for (int i = 0; i < 8; i++) run(2, 4, W'($urandom), W'($urandom), "rnd_c5");
      run(2, 4, 19'h7FFFF, 19'h00001, "c5_ripple");
      run(2, 4, 19'h3C000, 19'h04000, "c5_topslice");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/csa_final_adder_seq.md
Name: csa_final_adder_seq

Overview:
- Carry-propagate stage placed directly after the 5x16 carry-save compressor.
- Takes the compressor's 19-bit carry vector and 19-bit sum vector and resolves them into one binary total.
- Adds CHUNK bits per cycle, passing a registered carry from one slice to the next, so a narrow adder serves the whole width.
- Uses valid/ready handshakes on both sides so it can sit between pipeline registers.

Parameters:
- W, 19, operand and result width in bits (compressor output width).
- CHUNK, 4, bits resolved per ADD cycle; legal range 1..W.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  cv_in/sv_in hold a valid pair.
- in_ready  output  1  block can accept a pair.
- cv_in  input  W  carry vector (compressor out1).
- sv_in  input  W  sum vector (compressor out2).
- out_valid  output  1  sum_out is valid.
- out_ready  input  1  consumer accepts sum_out.
- sum_out  output  W  resolved total, (cv_in + sv_in) mod 2^W.
- busy  output  1  high in ADD and DONE states.

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, sum_out=0, internal carry=0, slice index=0.
- Definitions: N = ceil(W/CHUNK), so N=5 at the defaults.
- State IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch cv_in and sv_in, clear carry and index, go to ADD.
  - Input pins are don't-care after acceptance.
- State ADD:
  - in_ready=0.
  - Each cycle adds slice idx: bits [idx*CHUNK +: CHUNK] of both latched operands plus the carry register.
  - Writes the slice result into the result register and registers the slice carry-out.
  - Increments idx.
  - After slice N-1, go to DONE.
  - Last slice when W%CHUNK!=0: only the low W%CHUNK bits are valid. Bits above W-1 are neither written nor used. The carry-out is taken from bit W-1.
- State DONE:
  - out_valid=1; sum_out holds steady.
  - On out_valid&out_ready, go to IDLE.
  - out_valid drops on the next cycle and in_ready rises on the same cycle.
  - There is no same-cycle accept-while-done bypass.
- Latency: first out_valid cycle occurs N cycles after the accept edge; throughput is one result per N+2 cycles.
- sum_out updates only during ADD and keeps its last value in IDLE.
- Carry-out beyond bit W-1 is discarded. For legal compressor pairs it is always 0: max total = 5*65535 = 327675 < 2^19.
- Reset asserted in any state returns the block to its reset values at the next edge. The in-flight operation is lost and no out_valid is produced for it.
- in_valid asserted in ADD or DONE is ignored, with no latching. The upstream stage must hold its data until in_ready.
- out_ready asserted outside DONE has no effect.

Optional Feature:
- Macro CSA_FINAL_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit, reset 0).
  - ovf is the registered carry-out from bit W-1 of the last slice, updated on the same edge as the final sum bits.
  - Valid while out_valid=1 and held until the next operation completes.
  - Flags an illegal or corrupted carry-save pair.
- Undefined: no ovf port, and the final carry-out is dropped.

Test Plan:
- Reset, then cv_in=19'h00002, sv_in=19'h00001 held with in_valid=1, out_ready=1 -> out_valid rises exactly 5 cycles after accept; sum_out=19'h00003; in_ready returns 1 the cycle after the handshake.
- Pair from compressing five operands of 16'hFFFF -> sum_out=19'h4FFFB (327675); ovf=0 when CSA_FINAL_OVF_EN is defined.
- cv_in=19'h7FFFF, sv_in=19'h00001 (ripple through every slice) -> sum_out=19'h00000; ovf=1 when the macro is defined.
- out_ready held 0 for 10 cycles in DONE -> out_valid stays 1, sum_out stable, in_ready stays 0; new in_valid is not latched; releasing out_ready completes the handshake once.
- rst_n driven low during the 3rd ADD cycle -> next cycle in_ready=1, out_valid=0, sum_out=0; a following pair 19'h12345 + 19'h01111 gives 19'h13456.
- Parameter sweep CHUNK=19 (N=1), then CHUNK=5 (N=4, 4-bit last slice) -> random pairs match (cv+sv) mod 2^19; latency equals N in each case.
